// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional stall counter width lives here; the counter itself is enabled by FIFO_ARB_STALL_CNT_EN.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Index width for n producers; never narrower than one bit.
    function automatic int grant_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = grant_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0]   w_sum [NUM_REQ];
    logic [IDX_W-1:0] w_pos [NUM_REQ];

    // w_pos[k] is the producer examined k-th in round-robin order.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pos
        assign w_sum[gi] = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
        assign w_pos[gi] = (w_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                         ? IDX_W'(w_sum[gi] - (IDX_W+1)'(NUM_REQ))
                         : IDX_W'(w_sum[gi]);
    end

    always_comb begin
        valid = |req;
        idx   = '0;
        // Walk from the back so the earliest position in the order wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[w_pos[k]]) begin
                idx = w_pos[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts of up to MAX_BURST.
// Define FIFO_ARB_STALL_CNT_EN to add the stall_clr input and the saturating stall_cnt output.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int IDX_W     = grant_idx_w(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          w_full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    input  logic                          stall_clr,
    output logic [STALL_CNT_W-1:0]        stall_cnt
`endif
);

    arb_state_t       r_state, r_state_next;
    logic [IDX_W-1:0] r_rr_ptr, r_rr_ptr_next;
    logic [IDX_W-1:0] r_grant_id, r_grant_id_next;
    logic [CNT_W-1:0] r_burst_cnt, r_burst_cnt_next;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_req_g;
    logic             w_xfer;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx)
    );

    assign w_req_g  = req[r_grant_id];
    assign w_xfer   = (r_state == BURST) && w_req_g && !w_full;
    assign w_en     = w_xfer;
    assign busy     = (r_state == BURST);
    assign grant_id = r_grant_id;
    assign w_data   = (r_state == BURST) ? req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH]
                                         : '0;

    always_comb begin
        ack = '0;
        if (w_xfer) begin
            ack[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= r_state_next;
            r_rr_ptr    <= r_rr_ptr_next;
            r_grant_id  <= r_grant_id_next;
            r_burst_cnt <= r_burst_cnt_next;
        end
    end

    always_comb begin
        r_state_next     = r_state;
        r_rr_ptr_next    = r_rr_ptr;
        r_grant_id_next  = r_grant_id;
        r_burst_cnt_next = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    r_grant_id_next  = w_pick_idx;
                    r_rr_ptr_next    = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                          : w_pick_idx + 1'b1;
                    r_burst_cnt_next = '0;
                    r_state_next     = BURST;
                end
            end
            BURST: begin
                // A dropped request ends the burst even if the FIFO is full.
                if (!w_req_g) begin
                    r_state_next = IDLE;
                end else if (!w_full) begin
                    r_burst_cnt_next = r_burst_cnt + 1'b1;
                    if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        r_state_next = IDLE;
                    end
                end
            end
            default: r_state_next = IDLE;
        endcase
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if ((r_state == BURST) && w_req_g && w_full && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
